pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline: drives PC write-enable, IF/ID stall/flush,
//  ID/EX bubble insertion and global freeze. Handles load-use hazards, taken-branch flush in ID,

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types for the pipeline hazard sequencer. It provides the
//             sequencer state encoding, the default register-address width
//             and the bundle of stage-register control strobes.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // These are the control strobes that go to the stage registers.
    typedef struct packed {
        logic pc_write;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_bubble;
        logic freeze;
    } ctrl_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that stops at its all-ones value instead of
//             wrapping back to zero.
//  Ports    : clk_i  - clock
//             rst_i  - synchronous reset, active-low
//             inc_i  - count one event this cycle
//             cnt_o  - current count (W bits)
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central sequencer for the 5-stage pipeline. It decodes the PC
//             write-enable, the IF/ID stall and flush, the ID/EX bubble and
//             the global freeze from the current state and the hazard inputs.
//             It also sequences start, halt, drain and done, and it counts
//             stall and flush cycles.
//  Ports    : clk_i, rst_i          - clock, synchronous active-low reset
//             start_i               - begin execution (sampled in IDLE)
//             id_rs1_i, id_rs2_i    - source registers of the ID instruction
//             ex_rd_i, ex_mem_read_i- destination / load flag of EX instr.
//             branch_taken_i        - ID branch resolved taken
//             halt_i                - ID holds a halt instruction
//             mem_stall_i           - data memory busy
//             pc_write_o .. freeze_o- stage-register controls (combinational)
//             done_o                - pipeline drained after halt (registered)
//             stall_cnt_o           - load-use stall / freeze cycles
//             flush_cnt_o           - branch flush cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    input  logic              branch_taken_i,
    input  logic              halt_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              freeze_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // The drain counter only needs to hold DRAIN_CYCLES-1.
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] C_DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    state_t         r_state;
    logic [DCW-1:0] r_drain_cnt;
    logic           r_done;

    logic  w_load_use;
    ctrl_t w_ctrl;
    logic  w_stall_inc;
    logic  w_flush_inc;

    // A load that writes x0 never creates a hazard, because x0 is hard-wired.
    assign w_load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                        ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    // ------------------------------------------------------------------
    // Output decode. It is purely combinational, so every action takes
    // effect on the same clock edge as the condition that causes it.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl      = '0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ctrl.if_id_flush  = 1'b1;
                w_ctrl.id_ex_bubble = 1'b1;
            end
            ST_RUN: begin
                if (mem_stall_i) begin
                    w_ctrl.freeze      = 1'b1;
                    w_ctrl.if_id_stall = 1'b1;
                    w_stall_inc        = 1'b1;
                end else if (w_load_use) begin
                    // The branch flush is held back here. The branch is
                    // resolved again next cycle, once the loaded value can
                    // be forwarded.
                    w_ctrl.if_id_stall  = 1'b1;
                    w_ctrl.id_ex_bubble = 1'b1;
                    w_stall_inc         = 1'b1;
                end else if (halt_i) begin
                    w_ctrl.if_id_flush = 1'b1;
                end else if (branch_taken_i) begin
                    w_ctrl.pc_write    = 1'b1;
                    w_ctrl.if_id_flush = 1'b1;
                    w_flush_inc        = 1'b1;
                end else begin
                    w_ctrl.pc_write = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_ctrl.if_id_flush  = 1'b1;
                w_ctrl.id_ex_bubble = 1'b1;
                w_ctrl.freeze       = mem_stall_i;
                w_stall_inc         = mem_stall_i;
            end
            default: begin
                // In DONE the pipeline keeps the drained outputs, and the
                // counters no longer advance.
                w_ctrl.if_id_flush  = 1'b1;
                w_ctrl.id_ex_bubble = 1'b1;
                w_ctrl.freeze       = mem_stall_i;
            end
        endcase
    end

    assign pc_write_o     = w_ctrl.pc_write;
    assign if_id_stall_o  = w_ctrl.if_id_stall;
    assign if_id_flush_o  = w_ctrl.if_id_flush;
    assign id_ex_bubble_o = w_ctrl.id_ex_bubble;
    assign freeze_o       = w_ctrl.freeze;
    assign done_o         = r_done;

    // ------------------------------------------------------------------
    // Sequencer with the drain down-counter and the registered done flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!mem_stall_i && !w_load_use && halt_i) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= C_DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Frozen cycles do not count toward the drain.
                    if (!mem_stall_i) begin
                        if (r_drain_cnt == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DCW'(1);
                        end
                    end
                end
                default: begin
                    r_done <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl. Two instances
//             share one stimulus stream: instance A has a wide counter and a
//             three-cycle drain, and instance B has a 2-bit counter and a
//             one-cycle drain. A behavioural model predicts every output on
//             every cycle. A few literal expectations pin the model itself.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, ex_mem_read, branch_taken, halt, mem_stall;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;

    logic        pc_a, st_a, fl_a, bb_a, fz_a, done_a;
    logic [15:0] scnt_a, fcnt_a;
    logic        pc_b, st_b, fl_b, bb_b, fz_b, done_b;
    logic [1:0]  scnt_b, fcnt_b;

    pipeline_hazard_ctrl #(.REG_AW(AW), .DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rd_i(ex_rd),
        .ex_mem_read_i(ex_mem_read), .branch_taken_i(branch_taken),
        .halt_i(halt), .mem_stall_i(mem_stall),
        .pc_write_o(pc_a), .if_id_stall_o(st_a), .if_id_flush_o(fl_a),
        .id_ex_bubble_o(bb_a), .freeze_o(fz_a), .done_o(done_a),
        .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .DRAIN_CYCLES(1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rd_i(ex_rd),
        .ex_mem_read_i(ex_mem_read), .branch_taken_i(branch_taken),
        .halt_i(halt), .mem_stall_i(mem_stall),
        .pc_write_o(pc_b), .if_id_stall_o(st_b), .if_id_flush_o(fl_b),
        .id_ex_bubble_o(bb_b), .freeze_o(fz_b), .done_o(done_b),
        .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

    // ---------------- behavioural model ----------------
    int m_state [2];
    int m_remain[2];    // non-frozen drain cycles still owed
    int m_stall [2];
    int m_flush [2];
    int m_done  [2];
    int drain_len[2] = '{3, 1};
    int cnt_max  [2] = '{65535, 3};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hazard();
        return ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    endfunction

    // Compare both instances against the model for the current state and inputs.
    task automatic compare();
        int e_pc, e_st, e_fl, e_bb, e_fz;
        for (int k = 0; k < 2; k++) begin
            e_pc = 0; e_st = 0; e_fl = 0; e_bb = 0; e_fz = 0;
            if (m_state[k] == M_IDLE) begin
                e_fl = 1; e_bb = 1;
            end else if (m_state[k] == M_RUN) begin
                if (mem_stall)         begin e_fz = 1; e_st = 1; end
                else if (hazard())     begin e_st = 1; e_bb = 1; end
                else if (halt)         begin e_fl = 1; end
                else if (branch_taken) begin e_pc = 1; e_fl = 1; end
                else                   begin e_pc = 1; end
            end else begin
                e_fl = 1; e_bb = 1; e_fz = int'(mem_stall);
            end
            if (k == 0) begin
                chk("a_pc_write", int'(pc_a), e_pc);
                chk("a_if_id_stall", int'(st_a), e_st);
                chk("a_if_id_flush", int'(fl_a), e_fl);
                chk("a_id_ex_bubble", int'(bb_a), e_bb);
                chk("a_freeze", int'(fz_a), e_fz);
                chk("a_done", int'(done_a), m_done[0]);
                chk("a_stall_cnt", int'(scnt_a), m_stall[0]);
                chk("a_flush_cnt", int'(fcnt_a), m_flush[0]);
            end else begin
                chk("b_pc_write", int'(pc_b), e_pc);
                chk("b_if_id_stall", int'(st_b), e_st);
                chk("b_if_id_flush", int'(fl_b), e_fl);
                chk("b_id_ex_bubble", int'(bb_b), e_bb);
                chk("b_freeze", int'(fz_b), e_fz);
                chk("b_done", int'(done_b), m_done[1]);
                chk("b_stall_cnt", int'(scnt_b), m_stall[1]);
                chk("b_flush_cnt", int'(fcnt_b), m_flush[1]);
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        bit lu;
        lu = hazard();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_state[k] = M_IDLE; m_remain[k] = 0;
                m_stall[k] = 0; m_flush[k] = 0; m_done[k] = 0;
            end else begin
                case (m_state[k])
                    M_IDLE: if (start) m_state[k] = M_RUN;
                    M_RUN: begin
                        if (mem_stall || lu)
                            m_stall[k] = (m_stall[k] < cnt_max[k]) ? m_stall[k] + 1 : m_stall[k];
                        else if (halt) begin
                            m_state[k] = M_DRAIN; m_remain[k] = drain_len[k];
                        end else if (branch_taken)
                            m_flush[k] = (m_flush[k] < cnt_max[k]) ? m_flush[k] + 1 : m_flush[k];
                    end
                    M_DRAIN: begin
                        if (mem_stall)
                            m_stall[k] = (m_stall[k] < cnt_max[k]) ? m_stall[k] + 1 : m_stall[k];
                        else begin
                            m_remain[k]--;
                            if (m_remain[k] == 0) begin
                                m_state[k] = M_DONE; m_done[k] = 1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge. The comparison runs
    // at the falling edge.
    task automatic drive(input bit rn, input bit st, input int rs1, input int rs2,
                         input int rd, input bit mr, input bit br, input bit hl,
                         input bit ms);
        rst_n = rn; start = st; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
        ex_rd = AW'(rd); ex_mem_read = mr; branch_taken = br; halt = hl;
        mem_stall = ms;
        #4;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_plain();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int drain_ticks;
    int b_done_at;

    initial begin
        rst_n = 0; start = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; branch_taken = 0; halt = 0; mem_stall = 0;
        @(posedge clk);
        model_edge();
        #1;

        // Start from IDLE.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_pc_write", int'(pc_a), 0);
        chk("idle_flush", int'(fl_a), 1);
        chk("idle_bubble", int'(bb_a), 1);
        chk("reset_stall_cnt", int'(scnt_a), 0);
        tick();
        run_plain();
        chk("run_pc_write", int'(pc_a), 1);
        tick();

        // Load-use on rs2.
        drive(1, 0, 0, 5, 5, 1, 0, 0, 0);
        chk("lu_pc_write", int'(pc_a), 0);
        chk("lu_stall", int'(st_a), 1);
        chk("lu_bubble", int'(bb_a), 1);
        tick();

        // A load to x0 is not a hazard, so the taken branch flushes.
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("lu_stall_cnt", int'(scnt_a), 1);
        chk("x0_stall", int'(st_a), 0);
        chk("br_flush", int'(fl_a), 1);
        tick();

        // Load-use and a branch in the same cycle: the stall wins.
        drive(1, 0, 3, 0, 3, 1, 1, 0, 0);
        chk("br_flush_cnt", int'(fcnt_a), 1);
        chk("lu_br_stall", int'(st_a), 1);
        chk("lu_br_noflush", int'(fl_a), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("lu_br_flush_cnt_held", int'(fcnt_a), 1);
        chk("retry_flush", int'(fl_a), 1);
        tick();

        // Five memory-stall cycles saturate instance B's 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
            if (i == 0) chk("ms_freeze", int'(fz_a), 1);
            tick();
        end
        run_plain();
        chk("flush_cnt_2", int'(fcnt_a), 2);
        chk("stall_cnt_a_7", int'(scnt_a), 7);
        chk("stall_cnt_b_sat", int'(scnt_b), 3);
        tick();

        // Halt, and then two frozen cycles at the start of the drain.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("halt_pc_write", int'(pc_a), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drain_ticks = 2;
        b_done_at   = -1;
        for (int i = 0; i < 12; i++) begin
            run_plain();
            if (done_b && b_done_at < 0) b_done_at = drain_ticks;
            if (done_a) break;
            tick();
            drain_ticks++;
        end
        chk("a_done_latency", drain_ticks, 5);
        chk("b_done_latency", b_done_at, 3);
        tick();

        // A reset during a frozen drain cycle returns both instances to IDLE.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        run_plain();
        chk("rst_drain_idle_flush", int'(fl_a), 1);
        chk("rst_drain_pc_write", int'(pc_a), 0);
        chk("rst_drain_freeze", int'(fz_a), 0);
        chk("rst_drain_stall_cnt", int'(scnt_a), 0);
        chk("rst_drain_done", int'(done_a), 0);
        tick();

        // Random traffic. Small register values make hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
